// File: rtl/burp_pkg.sv
// Shared definitions for the BURP fetch path: opcode map, fetch state encoding
// and the default reset PC.
package burp_pkg;

    localparam logic [3:0] OP_JC   = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_MVI  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_SC   = 4'h6;
    localparam logic [3:0] OP_CC   = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h4;
    localparam logic [3:0] OP_POP  = 4'h3;
    localparam logic [3:0] OP_IN   = 4'h2;
    localparam logic [3:0] OP_OUT  = 4'h1;
    localparam logic [3:0] OP_NOP  = 4'h0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_EXEC  = 2'd3
    } fetch_state_t;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/burp_pc_reg.sv
// 16-bit program counter with independent byte loads and increment.
// Any byte load on an edge suppresses the increment; unloaded bytes hold.
module burp_pc_reg
    import burp_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_hi,
    input  logic        i_ld_lo,
    input  logic        i_inc,
    input  logic [7:0]  i_din,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;
    logic [15:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_ld_hi || i_ld_lo) begin
            if (i_ld_hi) w_pc_next[15:8] = i_din;
            if (i_ld_lo) w_pc_next[7:0]  = i_din;
        end else if (i_inc) begin
            w_pc_next = r_pc + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pc <= RESET_PC;
        else       r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/burp_fetch_unit.sv
// BURP instruction-fetch responder: owns the PC, reads program memory and holds
// the fetched byte for the controller. Optional fetch timeout: BURP_FETCH_TIMEOUT_EN.
module burp_fetch_unit
    import burp_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCinc,
    input  logic        END,
    input  logic        PCHin,
    input  logic        PCLin,
    input  logic        PCHout,
    input  logic        PCLout,
    input  logic        IRin,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  instr,
    output logic [3:0]  opcode,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_t r_state, w_next_state;
    logic [15:0]  w_pc;
    logic [7:0]   r_instr;
    logic         r_instr_valid;
    logic         r_mem_rd;
    logic [15:0]  r_mem_addr;
    logic         r_busy;
    logic         w_timeout;

    burp_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_ld_hi (PCHin),
        .i_ld_lo (PCLin),
        .i_inc   (PCinc && (r_state == ST_EXEC)),
        .i_din   (bus_in),
        .o_pc    (w_pc)
    );

`ifdef BURP_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fetch_err;

    assign w_timeout = (r_state == ST_WAIT) && !mem_ready &&
                       (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state == ST_FETCH)
                r_wait_cnt <= '0;
            else if ((r_state == ST_WAIT) && !mem_ready)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout)
                r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: w_next_state = ST_WAIT;
            ST_WAIT:  if (mem_ready || w_timeout) w_next_state = ST_HOLD;
            ST_HOLD:  if (IRin) w_next_state = ST_EXEC;
            ST_EXEC:  if (PCinc || END) w_next_state = ST_FETCH;
            default:  w_next_state = ST_FETCH;
        endcase
    end

    // Memory port and instruction register are registered so they are quiet out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr       <= 8'h00;
            r_instr_valid <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_busy        <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_FETCH) || (w_next_state == ST_WAIT);
            case (r_state)
                ST_FETCH: begin
                    r_mem_addr <= w_pc;
                    r_mem_rd   <= 1'b1;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        r_instr       <= mem_rdata;
                        r_instr_valid <= 1'b1;
                        r_mem_rd      <= 1'b0;
                    end else if (w_timeout) begin
                        r_instr       <= {OP_NOP, 4'h0};
                        r_instr_valid <= 1'b1;
                        r_mem_rd      <= 1'b0;
                    end
                end
                ST_HOLD: if (IRin) r_instr_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus_out     = PCHout ? w_pc[15:8] : (PCLout ? w_pc[7:0] : 8'h00);
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign instr       = r_instr;
    assign opcode      = r_instr[7:4];
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;

endmodule
